// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types for the Ethernet RX frame FIFO
package eth_pkg;

    typedef enum logic {
        WR_NORMAL = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/eth_sdp_ram.sv
// rtl/eth_sdp_ram.sv - single-clock simple dual-port RAM with registered read
module eth_sdp_ram #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [1 << ADDR_WIDTH];
    logic [WIDTH-1:0] r_rdata;

    // Read register holds its value when not enabled; the FIFO relies on that while stalled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - store-and-forward RX frame FIFO that drops bad and oversize frames
module eth_rx_frame_fifo
    import eth_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter bit DROP_BAD_FRAME = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              status_overflow,
    output logic              status_bad_frame,
    output logic              status_good_frame
);

    localparam int WIDTH = DROP_BAD_FRAME ? 9 : 10;
    localparam logic [ADDR_WIDTH:0] PTR_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    wr_state_t             r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [ADDR_WIDTH:0]   w_wr_ptr_nxt, w_wr_commit_nxt, w_wr_ptr_inc;
    logic                  w_full, w_empty, w_we, w_fetch, w_adv;
    logic                  w_ovf, w_bad, w_good;
    logic                  r_ovf, r_bad, r_good;
    logic [WIDTH-1:0]      w_wdata, w_rdata;
    logic                  w_rd_tuser;
    logic                  r_ram_valid, r_out_valid, r_out_last, r_out_user;
    logic [BYTE_W-1:0]     r_out_data;

    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_full       = (r_wr_ptr - r_rd_ptr) == PTR_DEPTH;
    assign w_empty      = (r_rd_ptr == r_wr_commit);

    always_comb begin
        w_state_nxt     = r_state;
        w_we            = 1'b0;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_commit_nxt = r_wr_commit;
        w_ovf           = 1'b0;
        w_bad           = 1'b0;
        w_good          = 1'b0;
        case (r_state)
            WR_NORMAL: begin
                if (s_axis_tvalid) begin
                    if (w_full) begin
                        // Rewind to the last committed frame; the rest of this frame is discarded.
                        w_wr_ptr_nxt = r_wr_commit;
                        w_ovf        = 1'b1;
                        if (!s_axis_tlast) begin
                            w_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_we = 1'b1;
                        if (s_axis_tlast && s_axis_tuser && DROP_BAD_FRAME) begin
                            w_wr_ptr_nxt = r_wr_commit;
                            w_bad        = 1'b1;
                        end else begin
                            w_wr_ptr_nxt = w_wr_ptr_inc;
                            if (s_axis_tlast) begin
                                w_wr_commit_nxt = w_wr_ptr_inc;
                                w_good          = 1'b1;
                            end
                        end
                    end
                end
            end
            WR_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = WR_NORMAL;
                end
            end
            default: w_state_nxt = WR_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WR_NORMAL;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_ovf       <= 1'b0;
            r_bad       <= 1'b0;
            r_good      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_ovf       <= w_ovf;
            r_bad       <= w_bad;
            r_good      <= w_good;
        end
    end

    generate
        if (DROP_BAD_FRAME) begin : g_no_user
            assign w_wdata    = {s_axis_tlast, s_axis_tdata};
            assign w_rd_tuser = 1'b0;
        end else begin : g_user
            assign w_wdata    = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
            assign w_rd_tuser = w_rdata[9];
        end
    endgenerate

    eth_sdp_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_fetch),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    // The RAM read register and output register shift together, so a fetch never overwrites unread data.
    assign w_adv   = !r_out_valid || m_axis_tready;
    assign w_fetch = !w_empty && w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_ram_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_adv) begin
                r_ram_valid <= w_fetch;
                r_out_valid <= r_ram_valid;
                if (r_ram_valid) begin
                    r_out_data <= w_rdata[BYTE_W-1:0];
                    r_out_last <= w_rdata[BYTE_W];
                    r_out_user <= w_rd_tuser;
                end
            end
        end
    end

    assign m_axis_tdata      = r_out_data;
    assign m_axis_tvalid     = r_out_valid;
    assign m_axis_tlast      = r_out_last;
    assign m_axis_tuser      = r_out_user;
    assign status_overflow   = r_ovf;
    assign status_bad_frame  = r_bad;
    assign status_good_frame = r_good;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - self-checking bench for eth_rx_frame_fifo (4096-byte and 64-byte instances)
module tb_eth_rx_frame_fifo;

    localparam int BIG_DEPTH   = 4096;
    localparam int SMALL_DEPTH = 64;
    localparam int DRAIN_LIMIT = 8000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;

    logic [7:0] b_tdata, sm_tdata;
    logic       b_tvalid, b_tlast, b_tuser, b_ovf, b_bad, b_good;
    logic       sm_tvalid, sm_tlast, sm_tuser, sm_ovf, sm_bad, sm_good;
    logic       b_tready = 1'b1;
    logic       sm_tready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_rx_frame_fifo #(.ADDR_WIDTH(12), .DROP_BAD_FRAME(1'b1)) u_big (
        .clk (clk), .rst_n (rst_n),
        .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tuser (s_tuser),
        .m_axis_tdata (b_tdata), .m_axis_tvalid (b_tvalid), .m_axis_tready (b_tready),
        .m_axis_tlast (b_tlast), .m_axis_tuser (b_tuser),
        .status_overflow (b_ovf), .status_bad_frame (b_bad), .status_good_frame (b_good)
    );

    eth_rx_frame_fifo #(.ADDR_WIDTH(6), .DROP_BAD_FRAME(1'b1)) u_small (
        .clk (clk), .rst_n (rst_n),
        .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tuser (s_tuser),
        .m_axis_tdata (sm_tdata), .m_axis_tvalid (sm_tvalid), .m_axis_tready (sm_tready),
        .m_axis_tlast (sm_tlast), .m_axis_tuser (sm_tuser),
        .status_overflow (sm_ovf), .status_bad_frame (sm_bad), .status_good_frame (sm_good)
    );

    bit rand_rdy = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        b_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output collectors: whole frames only, partial frames are forgotten on reset.
    logic [9:0] rx_b[$], cur_b[$], rx_s[$], cur_s[$];
    logic [9:0] prev_b, prev_s;
    bit         stall_b = 1'b0, stall_s = 1'b0;
    int         ovf_cnt_b = 0, bad_cnt_b = 0, good_cnt_b = 0, unstable_b = 0;
    int         ovf_cnt_s = 0, bad_cnt_s = 0, good_cnt_s = 0, unstable_s = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_b.delete();
            stall_b = 1'b0;
        end else begin
            if (stall_b && (b_tvalid !== 1'b1 || {b_tuser, b_tlast, b_tdata} !== prev_b)) unstable_b++;
            if (b_tvalid && b_tready) begin
                cur_b.push_back({b_tuser, b_tlast, b_tdata});
                if (b_tlast) begin
                    foreach (cur_b[i]) rx_b.push_back(cur_b[i]);
                    cur_b.delete();
                end
            end
            ovf_cnt_b  += int'(b_ovf);
            bad_cnt_b  += int'(b_bad);
            good_cnt_b += int'(b_good);
            stall_b = b_tvalid && !b_tready;
            prev_b  = {b_tuser, b_tlast, b_tdata};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_s.delete();
            stall_s = 1'b0;
        end else begin
            if (stall_s && (sm_tvalid !== 1'b1 || {sm_tuser, sm_tlast, sm_tdata} !== prev_s)) unstable_s++;
            if (sm_tvalid && sm_tready) begin
                cur_s.push_back({sm_tuser, sm_tlast, sm_tdata});
                if (sm_tlast) begin
                    foreach (cur_s[i]) rx_s.push_back(cur_s[i]);
                    cur_s.delete();
                end
            end
            ovf_cnt_s  += int'(sm_ovf);
            bad_cnt_s  += int'(sm_bad);
            good_cnt_s += int'(sm_good);
            stall_s = sm_tvalid && !sm_tready;
            prev_s  = {sm_tuser, sm_tlast, sm_tdata};
        end
    end

    // Reference model: a frame is delivered whole iff it fits the free space and is not bad.
    logic [9:0] exp_b[$], exp_s[$];
    int exp_ovf_b = 0, exp_bad_b = 0, exp_good_b = 0;
    int exp_ovf_s = 0, exp_bad_s = 0, exp_good_s = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int len, input bit bad, input bit ramp, input int free_s);
        logic [9:0] words[$];
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = ramp ? 8'(i) : 8'($urandom_range(0, 255));
            words.push_back({1'b0, (i == len - 1), d});
            s_tdata  = d;
            s_tvalid = 1'b1;
            s_tlast  = (i == len - 1);
            s_tuser  = bad && (i == len - 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (len > BIG_DEPTH) exp_ovf_b++;
        else if (bad) exp_bad_b++;
        else begin
            exp_good_b++;
            foreach (words[i]) exp_b.push_back(words[i]);
        end
        if (len > free_s) exp_ovf_s++;
        else if (bad) exp_bad_s++;
        else begin
            exp_good_s++;
            foreach (words[i]) exp_s.push_back(words[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_and_compare(input string tag);
        int n = 0;
        int bad_idx_b = -1;
        int bad_idx_s = -1;
        while ((rx_b.size() != exp_b.size() || rx_s.size() != exp_s.size()) && n < DRAIN_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(10);
        check({tag, " drain in time"}, 32'(n < DRAIN_LIMIT), 32'd1);
        check({tag, " big byte count"}, rx_b.size(), exp_b.size());
        check({tag, " small byte count"}, rx_s.size(), exp_s.size());
        for (int i = 0; i < exp_b.size() && i < rx_b.size(); i++)
            if (bad_idx_b < 0 && rx_b[i] !== exp_b[i]) bad_idx_b = i;
        for (int i = 0; i < exp_s.size() && i < rx_s.size(); i++)
            if (bad_idx_s < 0 && rx_s[i] !== exp_s[i]) bad_idx_s = i;
        check({tag, " big first bad index"}, bad_idx_b, -1);
        check({tag, " small first bad index"}, bad_idx_s, -1);
        check({tag, " big overflow pulses"}, ovf_cnt_b, exp_ovf_b);
        check({tag, " big bad pulses"}, bad_cnt_b, exp_bad_b);
        check({tag, " big good pulses"}, good_cnt_b, exp_good_b);
        check({tag, " small overflow pulses"}, ovf_cnt_s, exp_ovf_s);
        check({tag, " small bad pulses"}, bad_cnt_s, exp_bad_s);
        check({tag, " small good pulses"}, good_cnt_s, exp_good_s);
        check({tag, " big stall stability"}, unstable_b, 0);
        check({tag, " small stall stability"}, unstable_s, 0);
    endtask

    initial begin
        int sz_b, sz_s, rx_s_before;
        logic [9:0] first_word;

        rst_n = 1'b0;
        idle(3);
        check("reset tvalid", {31'd0, b_tvalid}, 32'd0);
        check("reset tdata", {24'd0, b_tdata}, 32'd0);
        check("reset tlast/tuser", {30'd0, b_tlast, b_tuser}, 32'd0);
        check("reset status", {29'd0, b_ovf, b_bad, b_good}, 32'd0);
        check("reset small tvalid", {31'd0, sm_tvalid}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Good 64-byte ramp frame and first-byte latency.
        send_frame(64, 1'b0, 1'b1, SMALL_DEPTH);
        check("latency edge+0 tvalid", {31'd0, b_tvalid}, 32'd0);
        idle(1);
        check("latency edge+1 tvalid", {31'd0, b_tvalid}, 32'd0);
        idle(1);
        check("latency edge+2 tvalid", {31'd0, b_tvalid}, 32'd1);
        check("latency edge+2 tdata", {24'd0, b_tdata}, 32'h00);
        check("latency edge+2 small tvalid", {31'd0, sm_tvalid}, 32'd1);
        drain_and_compare("good64");

        // Bad frame followed by a good frame.
        send_frame(60, 1'b1, 1'b0, SMALL_DEPTH);
        idle(2);
        send_frame(64, 1'b0, 1'b0, SMALL_DEPTH);
        drain_and_compare("bad60+good64");

        // Oversize for the 64-byte instance, then a short frame; single-byte frame too.
        send_frame(65, 1'b0, 1'b0, SMALL_DEPTH);
        idle(2);
        send_frame(10, 1'b0, 1'b0, SMALL_DEPTH);
        idle(2);
        send_frame(1, 1'b0, 1'b0, SMALL_DEPTH);
        drain_and_compare("oversize65+10+1");

        // Exact fill with output stalled: at most two bytes leave RAM into the output stages.
        sm_tready = 1'b0;
        rx_s_before = rx_s.size();
        first_word = 10'h000;
        sz_s = exp_s.size();
        send_frame(40, 1'b0, 1'b0, SMALL_DEPTH);
        first_word = exp_s[sz_s];
        send_frame(24, 1'b0, 1'b0, SMALL_DEPTH - 40 + 2);
        idle(2);
        send_frame(5, 1'b0, 1'b0, SMALL_DEPTH - 64 + 2);
        idle(6);
        check("fill stalled tvalid", {31'd0, sm_tvalid}, 32'd1);
        check("fill stalled head word", {22'd0, sm_tuser, sm_tlast, sm_tdata}, {22'd0, first_word});
        check("fill nothing delivered", rx_s.size(), rx_s_before);
        sm_tready = 1'b1;
        drain_and_compare("fill40+24+5");
        send_frame(64, 1'b0, 1'b0, SMALL_DEPTH);
        drain_and_compare("wrap64");

        // Random backpressure on the large instance.
        rand_rdy = 1'b1;
        send_frame(1, 1'b0, 1'b0, SMALL_DEPTH);
        idle(3);
        send_frame(1500, 1'b0, 1'b0, SMALL_DEPTH);
        drain_and_compare("backpressure");
        rand_rdy = 1'b0;

        // Reset while frame 2 is arriving and frame 1 is still being read out.
        sz_b = exp_b.size();
        sz_s = exp_s.size();
        send_frame(200, 1'b0, 1'b0, SMALL_DEPTH);
        idle(2);
        for (int i = 0; i < 50; i++) begin
            s_tdata  = 8'($urandom_range(0, 255));
            s_tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("frame1 still partial", rx_b.size(), sz_b);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("mid reset tvalid", {30'd0, b_tvalid, sm_tvalid}, 32'd0);
        check("mid reset tdata", {16'd0, b_tdata, sm_tdata}, 32'd0);
        check("mid reset status", {26'd0, b_ovf, b_bad, b_good, sm_ovf, sm_bad, sm_good}, 32'd0);
        while (exp_b.size() > sz_b) void'(exp_b.pop_back());
        while (exp_s.size() > sz_s) void'(exp_s.pop_back());
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(30, 1'b0, 1'b0, SMALL_DEPTH);
        drain_and_compare("after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_fifo.md
ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning log2 of the byte storage depth (DEPTH = 2^ADDR_WIDTH).
REQ-002 SHALL have parameter DROP_BAD_FRAME, default 1, meaning that frames ending with s_axis_tuser=1 are discarded; 0 means they are stored with tuser=1 on their last byte.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, exactly as already decided for this block.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, i.e. the MAC receive clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port s_axis_tdata, input, 8 bits: received byte from the MAC RX stream.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: byte valid. There is no tready; input is never stalled.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: last byte of frame.
REQ-009 SHALL have port s_axis_tuser, input, 1 bit: bad frame, qualified with tlast.
REQ-010 SHALL have port m_axis_tdata, output, 8 bits: buffered byte.
REQ-011 SHALL have ports m_axis_tvalid (output), m_axis_tready (input), m_axis_tlast (output) and m_axis_tuser (output), 1 bit each, forming the AXI-stream output.
REQ-012 SHALL have ports status_overflow, status_bad_frame and status_good_frame, outputs, 1 bit each: single-cycle event pulses.

Function
REQ-013 SHALL store bytes in a DEPTH x 9 RAM, where the 9-bit word is {tlast, tdata}. When DROP_BAD_FRAME=0, tuser is also stored, making each word DEPTH x 10.
REQ-014 SHALL keep three pointers, each ADDR_WIDTH+1 bits with modulo wrap-around: wr_ptr (current write), wr_commit (end of last committed frame), rd_ptr.
REQ-015 SHALL define full as wr_ptr - rd_ptr == DEPTH, and empty as rd_ptr == wr_commit.
REQ-016 SHALL implement a write FSM with two states, NORMAL and DROP. Reset state is NORMAL.
REQ-017 In NORMAL, on a valid byte with the FIFO not full: write the word at wr_ptr and increment wr_ptr.
REQ-018 In NORMAL, on a valid byte with the FIFO full: do not write, set wr_ptr to wr_commit, and pulse status_overflow. Then go to DROP if tlast=0, or stay in NORMAL if tlast=1.
REQ-019 In DROP: discard all bytes. On a valid byte with tlast=1, return to NORMAL with no further pulse.
REQ-020 On a tlast byte written in NORMAL with tuser=1 and DROP_BAD_FRAME=1: set wr_ptr to wr_commit and pulse status_bad_frame.
REQ-021 On any other tlast byte written in NORMAL: set wr_commit to wr_ptr+1 and wr_ptr to wr_ptr+1, and pulse status_good_frame.
REQ-022 SHALL never write a frame longer than DEPTH bytes in full; such a frame is always dropped by REQ-018.
REQ-023 SHALL never present uncommitted bytes on the output.
REQ-024 SHALL use a read pipeline of RAM read plus one output register. A byte at rd_ptr is fetched whenever not empty and the output register is empty or being consumed (m_axis_tvalid & m_axis_tready).
REQ-025 SHALL, with the FIFO empty and m_axis_tready=1, assert m_axis_tvalid with the first byte exactly 2 cycles after the edge that accepted the committing tlast.
REQ-026 SHALL sustain 1 byte per cycle on the output while not empty and tready=1.
REQ-027 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-028 SHALL allow a write, a commit and a read in the same cycle without loss. Full is evaluated against the rd_ptr value before that cycle's read.
REQ-029 SHALL accept a 1-byte frame (tlast on the first byte) as a complete frame.
REQ-030 SHALL hold the status pulse outputs at 0 in every cycle except their event cycle.

Reset
REQ-031 On rst_n=0, SHALL asynchronously set the following to 0: all pointers, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, all status outputs, and the output register valid flag.
REQ-032 On rst_n=0, SHALL set the write FSM to NORMAL.
REQ-033 SHALL lose all stored and partial frames on reset; RAM contents need not be cleared.
REQ-034 SHALL, after rst_n deasserts mid-frame on the input, store the remaining bytes of that frame and deliver them as a frame when its tlast commits per REQ-021.

Structure
REQ-035 SHALL place the write FSM state encoding (NORMAL/DROP) in the shared package eth_pkg.
REQ-036 SHALL instantiate one sub-module, eth_sdp_ram: a simple dual-port RAM with a single clock, registered read and parameterised width/depth.
REQ-037 SHALL keep the pointer and FSM logic in eth_rx_frame_fifo itself.

Verification
REQ-038 Good frame: 64 bytes 0x00..0x3F, tuser=0, tready=1 -> identical 64 bytes out with tlast on 0x3F; one status_good_frame pulse; first byte 2 cycles after the tlast edge.
REQ-039 Bad frame: 60 bytes with tuser=1 on tlast, then a 64-byte good frame -> only the good frame appears; one status_bad_frame pulse and one status_good_frame pulse.
REQ-040 Oversize frame: ADDR_WIDTH=6, one frame of 65 bytes, then a 10-byte frame -> one status_overflow pulse on byte 65; only the 10-byte frame appears.
REQ-041 Exact fill: ADDR_WIDTH=6, tready=0, frames of 40 and 24 bytes, then a 5-byte frame; then release tready -> 40 and 24 are delivered, 5 is dropped with status_overflow; pointers wrap correctly on the next 64-byte frame.
REQ-042 Backpressure: tready toggled randomly during a 1-byte frame and a 1500-byte frame -> stable output while stalled; no loss, duplication or reordering.
REQ-043 Mid-operation reset: rst_n pulsed low while frame 2 is being written and frame 1 is partly read -> outputs are 0 immediately; no bytes of frame 1 or frame 2 ever appear afterwards.
